pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Sequential hazard, flush and exception sequencer for the 5-stage MIPS pipeline. It sits beside the combinational instruction decoder and owns every stall, flush and PC-select decision. It adds load-use stalls, a multi-cycle multiply/divide wait counter, and a registered exception FSM with EPC/cause capture and ERET return. Exception code width, register-address width and multiply/divide latency are parameters.

## Interface
- `REG_AW`, 5, register address width
- `EXC_W`, 4, exception cause code width
- `MD_LAT`, 8, multi-cycle op latency in cycles (≥2)
- `PC_W`, 32, PC width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `id_rs`, `id_rt`  in  REG_AW  source registers of instruction in ID
- `id_uses_rt`  in  1  ID instruction reads rt
- `ex_memread`  in  1  EX instruction is a load
- `ex_rd`  in  REG_AW  EX destination register
- `id_isbr`, `id_isj`  in  1  taken branch / jump resolved in ID
- `ex_mis`  in  1  misprediction resolved in EX
- `ex_md_start`  in  1  multi-cycle op entering execution (one-cycle pulse)
- `exc_valid`  in  1  exception raised this cycle
- `exc_code`  in  EXC_W  cause code
- `exc_pc`  in  PC_W  PC of the faulting instruction
- `eret`  in  1  ERET decoded in ID
- `pc_sel`  out  2  00 seq, 01 branch/jump target, 10 exception vector, 11 EPC
- `stall_if`, `stall_id`  out  1  hold PC / IF-ID register
- `flush_if`, `flush_id`, `flush_ex`  out  1  insert bubble into IF/ID, ID/EX, EX/MEM
- `md_busy`  out  1  multi-cycle unit occupied
- `epc`  out  PC_W  captured exception PC
- `cause`  out  EXC_W  captured cause
- `in_exc`  out  1  handler executing
- `double_fault`  out  1  sticky: exception seen while `in_exc`

## Operation
- FSM states:
  - `RUN`: normal operation.
  - `MD_WAIT`: multi-cycle op in flight.
  - `EXC_FLUSH`: one cycle.
  - `EXC_VEC`: one cycle.
- Priority in `RUN`, highest first:
  1. `exc_valid`
  2. `eret`
  3. `ex_mis`
  4. `ex_md_start`
  5. load-use
  6. `id_isbr|id_isj`
- Exception, taken only when `in_exc`=0:
  - Same cycle: `flush_if`/`flush_id`/`flush_ex`=1, `stall_if`=1.
  - At the edge: `epc`←`exc_pc`, `cause`←`exc_code`, go to `EXC_FLUSH`.
  - `EXC_FLUSH`: all flushes=1.
  - `EXC_VEC`: `pc_sel`=10, `flush_if`=1, `in_exc`←1, then `RUN`.
- Exception while `in_exc`=1: ignored except `double_fault`←1 (cleared only by reset). `epc`/`cause` are not overwritten.
- ERET with `in_exc`=1: `pc_sel`=11, `flush_if`=1, `in_exc`←0 at the edge. ERET with `in_exc`=0 is a no-op.
- Mispredict: `pc_sel`=01, `flush_if`=`flush_id`=1.
- Load-use: `ex_memread` & `ex_rd`≠0 & (`ex_rd`==`id_rs` | (`id_uses_rt` & `ex_rd`==`id_rt`)).
  - Response: `stall_if`=`stall_id`=1, `flush_id`=1 for exactly one cycle.
- Branch/jump: `pc_sel`=01, `flush_if`=1.
- Multi-cycle op (`ex_md_start` in `RUN`):
  - Counter loads `MD_LAT-1`; `md_busy`=1; go to `MD_WAIT`.
  - `MD_WAIT` drives `stall_if`=`stall_id`=1 and `flush_ex`=1, and decrements the counter.
  - When count==0 and no exception: `md_busy`←0, return to `RUN`.
- Exception during `MD_WAIT` aborts the op: counter cleared, `md_busy`←0, exception sequence entered.
- `ex_md_start` outside `RUN` is ignored.

## Timing
- Reset (async, `rst_n`=0): state `RUN`, counter 0. `epc`=0, `cause`=0, `in_exc`=0, `double_fault`=0, `md_busy`=0.
- In `RUN` with no hazard inputs, every combinational output is 0.
- In `RUN`, stall/flush/`pc_sel` are combinational from inputs. In other states they depend on state only.
- Exception-to-vector latency: `pc_sel`=10 exactly two cycles after the cycle `exc_valid` is sampled.
- Total stall for a multi-cycle op: `MD_LAT` cycles, counting the start cycle as stall 0.
- Reset mid-sequence returns to `RUN` immediately. No partial EPC update survives.

## Structure
- Shared package `pipe_pkg`: `pc_sel` encodings (`PCS_SEQ`, `PCS_BR`, `PCS_VEC`, `PCS_EPC`), FSM state enum, default `EXC_W`/`REG_AW`.
- Sub-module `md_wait_cnt`: loadable down-counter with `load`, `abort` and `done`, width `$clog2(MD_LAT)`.

## Test plan
- Load-use: `ex_memread`=1, `ex_rd`=`id_rs`=5 → one cycle of `stall_if`=`stall_id`=`flush_id`=1. With `ex_rd`=0 → no stall.
- Multi-cycle op: `MD_LAT`=8, pulse `ex_md_start` → `md_busy` and stalls high for 8 cycles, then 0.
- Exception: `exc_valid`, `exc_code`=0xC, `exc_pc`=0x400010 → `epc`=0x400010, `cause`=0xC; `pc_sel`=10 at +2; then `in_exc`=1.
- Double fault: second `exc_valid` while `in_exc` → `epc` unchanged, `double_fault`=1. ERET → `pc_sel`=11, `in_exc`=0.
- Simultaneous `exc_valid`+`ex_mis`+load-use → exception wins, `pc_sel`≠01, no load-use stall pattern.
- Exception at `MD_WAIT` count 3 → `md_busy`=0 next cycle and the vector is reached. Async reset mid-`EXC_FLUSH` → all outputs at reset values.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared definitions for the pipeline hazard sequencer:
//               PC-select encodings, sequencer state enum, default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Default widths used when the top is instantiated without overrides
  localparam int DEF_REG_AW = 5;
  localparam int DEF_EXC_W  = 4;

  // Next-PC source select
  localparam logic [1:0] PCS_SEQ = 2'b00;  // PC + 4
  localparam logic [1:0] PCS_BR  = 2'b01;  // branch / jump / mispredict target
  localparam logic [1:0] PCS_VEC = 2'b10;  // exception vector
  localparam logic [1:0] PCS_EPC = 2'b11;  // return from exception

  // Sequencer states
  typedef enum logic [1:0] {
    ST_RUN       = 2'b00,
    ST_MD_WAIT   = 2'b01,
    ST_EXC_FLUSH = 2'b10,
    ST_EXC_VEC   = 2'b11
  } hz_state_t;

endpackage
`default_nettype wire

// File: rtl/md_wait_cnt.sv
`default_nettype none
// ============================================================================
// Module      : md_wait_cnt
// Description : Loadable down-counter timing a multi-cycle multiply/divide.
//               Loads MD_LAT-1, decrements on request, abort clears it.
//               done is high whenever the count is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module md_wait_cnt #(
  parameter int MD_LAT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  input  logic abort,
  output logic done
);

  localparam int CW = $clog2(MD_LAT);
  localparam logic [CW-1:0] c_load_val = CW'(MD_LAT - 1);
  localparam logic [CW-1:0] c_one      = CW'(1);

  logic [CW-1:0] r_count;

  // Count register: abort wins over load, load wins over decrement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (abort) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= c_load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - c_one;
    end
  end

  assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Stall / flush / PC-select sequencer for the 5-stage pipeline.
//               Handles load-use stalls, multi-cycle op waits, branch and
//               mispredict redirects, and the exception / ERET sequence with
//               EPC and cause capture.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW,
  parameter int EXC_W  = DEF_EXC_W,
  parameter int MD_LAT = 8,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              id_isbr,
  input  logic              id_isj,
  input  logic              ex_mis,
  input  logic              ex_md_start,
  input  logic              exc_valid,
  input  logic [EXC_W-1:0]  exc_code,
  input  logic [PC_W-1:0]   exc_pc,
  input  logic              eret,
  output logic [1:0]        pc_sel,
  output logic              stall_if,
  output logic              stall_id,
  output logic              flush_if,
  output logic              flush_id,
  output logic              flush_ex,
  output logic              md_busy,
  output logic [PC_W-1:0]   epc,
  output logic [EXC_W-1:0]  cause,
  output logic              in_exc,
  output logic              double_fault
);

  hz_state_t r_state;
  hz_state_t w_state_nxt;

  logic w_load_use;
  logic w_exc_take;
  logic w_eret_take;
  logic w_md_load;
  logic w_md_dec;
  logic w_md_abort;
  logic w_md_done;

  // A load in EX whose destination feeds the instruction in ID; r0 never hazards
  assign w_load_use = ex_memread && (ex_rd != '0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  md_wait_cnt #(
    .MD_LAT (MD_LAT)
  ) u_md_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_md_load),
    .dec   (w_md_dec),
    .abort (w_md_abort),
    .done  (w_md_done)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and pipeline controls; RUN decodes by priority, other states by state alone
  always_comb begin
    w_state_nxt = r_state;
    pc_sel      = PCS_SEQ;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    flush_if    = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    w_exc_take  = 1'b0;
    w_eret_take = 1'b0;
    w_md_load   = 1'b0;
    w_md_dec    = 1'b0;
    w_md_abort  = 1'b0;

    case (r_state)
      ST_RUN: begin
        // An exception inside the handler, or an ERET outside it, is ignored
        // and lets the lower-priority hazards through
        if (exc_valid && !in_exc) begin
          w_exc_take  = 1'b1;
          stall_if    = 1'b1;
          flush_if    = 1'b1;
          flush_id    = 1'b1;
          flush_ex    = 1'b1;
          w_state_nxt = ST_EXC_FLUSH;
        end else if (eret && in_exc) begin
          w_eret_take = 1'b1;
          pc_sel      = PCS_EPC;
          flush_if    = 1'b1;
        end else if (ex_mis) begin
          pc_sel   = PCS_BR;
          flush_if = 1'b1;
          flush_id = 1'b1;
        end else if (ex_md_start) begin
          w_md_load   = 1'b1;
          w_state_nxt = ST_MD_WAIT;
        end else if (w_load_use) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_id = 1'b1;
        end else if (id_isbr || id_isj) begin
          pc_sel   = PCS_BR;
          flush_if = 1'b1;
        end
      end

      ST_MD_WAIT: begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
        if (exc_valid && !in_exc) begin
          w_exc_take  = 1'b1;
          w_md_abort  = 1'b1;
          w_state_nxt = ST_EXC_FLUSH;
        end else if (w_md_done) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_md_dec = 1'b1;
        end
      end

      ST_EXC_FLUSH: begin
        flush_if    = 1'b1;
        flush_id    = 1'b1;
        flush_ex    = 1'b1;
        w_state_nxt = ST_EXC_VEC;
      end

      ST_EXC_VEC: begin
        pc_sel      = PCS_VEC;
        flush_if    = 1'b1;
        w_state_nxt = ST_RUN;
      end

      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // EPC / cause capture on the first (non-nested) exception only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epc   <= '0;
      cause <= '0;
    end else if (w_exc_take) begin
      epc   <= exc_pc;
      cause <= exc_code;
    end
  end

  // Handler flag set when the vector is issued, cleared by ERET; double fault is sticky
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_exc       <= 1'b0;
      double_fault <= 1'b0;
    end else begin
      if (w_eret_take) begin
        in_exc <= 1'b0;
      end else if (r_state == ST_EXC_VEC) begin
        in_exc <= 1'b1;
      end
      if (exc_valid && in_exc) begin
        double_fault <= 1'b1;
      end
    end
  end

  // Busy flag tracks occupancy of the wait state, including an abort leaving it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_busy <= 1'b0;
    end else begin
      md_busy <= (w_state_nxt == ST_MD_WAIT);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl: directed scenarios
//               plus randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int EXC_W  = 4;
  localparam int MD_LAT = 8;
  localparam int PC_W   = 32;

  // Expected {pc_sel[1:0], stall_if, stall_id, flush_if, flush_id, flush_ex}
  localparam logic [6:0] O_IDLE  = 7'b00_00000;
  localparam logic [6:0] O_LU    = 7'b00_11010;
  localparam logic [6:0] O_MDW   = 7'b00_11001;
  localparam logic [6:0] O_EXC   = 7'b00_10111;
  localparam logic [6:0] O_FLUSH = 7'b00_00111;
  localparam logic [6:0] O_VEC   = 7'b10_00100;
  localparam logic [6:0] O_ERET  = 7'b11_00100;
  localparam logic [6:0] O_MIS   = 7'b01_00110;
  localparam logic [6:0] O_BR    = 7'b01_00100;

  logic              clk;
  logic              rst_n;
  logic [REG_AW-1:0] id_rs, id_rt, ex_rd;
  logic              id_uses_rt, ex_memread, id_isbr, id_isj, ex_mis;
  logic              ex_md_start, exc_valid, eret;
  logic [EXC_W-1:0]  exc_code;
  logic [PC_W-1:0]   exc_pc;
  logic [1:0]        pc_sel;
  logic              stall_if, stall_id, flush_if, flush_id, flush_ex;
  logic              md_busy, in_exc, double_fault;
  logic [PC_W-1:0]   epc;
  logic [EXC_W-1:0]  cause;

  wire [6:0] comb_o = {pc_sel, stall_if, stall_id, flush_if, flush_id, flush_ex};

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural model: remaining stall cycles and remaining exception steps
  int               m_md_left;
  int               m_exc_steps;
  logic             m_in_exc, m_df;
  logic [PC_W-1:0]  m_epc;
  logic [EXC_W-1:0] m_cause;

  pipe_hazard_ctrl #(
    .REG_AW (REG_AW),
    .EXC_W  (EXC_W),
    .MD_LAT (MD_LAT),
    .PC_W   (PC_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_memread   (ex_memread),
    .ex_rd        (ex_rd),
    .id_isbr      (id_isbr),
    .id_isj       (id_isj),
    .ex_mis       (ex_mis),
    .ex_md_start  (ex_md_start),
    .exc_valid    (exc_valid),
    .exc_code     (exc_code),
    .exc_pc       (exc_pc),
    .eret         (eret),
    .pc_sel       (pc_sel),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .flush_if     (flush_if),
    .flush_id     (flush_id),
    .flush_ex     (flush_ex),
    .md_busy      (md_busy),
    .epc          (epc),
    .cause        (cause),
    .in_exc       (in_exc),
    .double_fault (double_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle();
    id_rs = '0; id_rt = '0; ex_rd = '0; id_uses_rt = 1'b0; ex_memread = 1'b0;
    id_isbr = 1'b0; id_isj = 1'b0; ex_mis = 1'b0; ex_md_start = 1'b0;
    exc_valid = 1'b0; exc_code = '0; exc_pc = '0; eret = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 3 units later
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    next_cycle();
    #3;
    tests_run++; if (comb_o !== O_IDLE) begin tests_failed++; $display("FAIL reset_comb: got %b want %b", comb_o, O_IDLE); end
    tests_run++; if ({md_busy, in_exc, double_fault} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags: got %b want 000", {md_busy, in_exc, double_fault}); end
    tests_run++; if ({epc, cause} !== '0) begin tests_failed++; $display("FAIL reset_epc_cause: got %h/%h want 0/0", epc, cause); end
    next_cycle();
    rst_n = 1'b1;
    #3;
    tests_run++; if (comb_o !== O_IDLE) begin tests_failed++; $display("FAIL reset_release_comb: got %b want %b", comb_o, O_IDLE); end
    next_cycle();
  endtask

  task automatic test_load_use();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; #3;
    tests_run++; if (comb_o !== O_LU) begin tests_failed++; $display("FAIL lu_rs: got %b want %b", comb_o, O_LU); end
    next_cycle(); idle(); #3;
    tests_run++; if (comb_o !== O_IDLE) begin tests_failed++; $display("FAIL lu_one_cycle: got %b want %b", comb_o, O_IDLE); end
    next_cycle();
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1; #3;
    tests_run++; if (comb_o !== O_IDLE) begin tests_failed++; $display("FAIL lu_rd_zero: got %b want %b", comb_o, O_IDLE); end
    next_cycle();
    ex_memread = 1'b1; ex_rd = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b1; #3;
    tests_run++; if (comb_o !== O_LU) begin tests_failed++; $display("FAIL lu_rt: got %b want %b", comb_o, O_LU); end
    next_cycle();
    id_uses_rt = 1'b0; #3;
    tests_run++; if (comb_o !== O_IDLE) begin tests_failed++; $display("FAIL lu_rt_not_used: got %b want %b", comb_o, O_IDLE); end
    next_cycle();
    ex_memread = 1'b0; id_rs = 5'd7; #3;
    tests_run++; if (comb_o !== O_IDLE) begin tests_failed++; $display("FAIL lu_not_load: got %b want %b", comb_o, O_IDLE); end
    next_cycle(); idle();
  endtask

  task automatic test_branch();
    id_isbr = 1'b1; #3;
    tests_run++; if (comb_o !== O_BR) begin tests_failed++; $display("FAIL br_taken: got %b want %b", comb_o, O_BR); end
    next_cycle(); idle();
    id_isj = 1'b1; #3;
    tests_run++; if (comb_o !== O_BR) begin tests_failed++; $display("FAIL jump: got %b want %b", comb_o, O_BR); end
    next_cycle(); idle();
    ex_mis = 1'b1; id_isbr = 1'b1; ex_memread = 1'b1; ex_rd = 5'd9; id_rs = 5'd9; #3;
    tests_run++; if (comb_o !== O_MIS) begin tests_failed++; $display("FAIL mispredict_prio: got %b want %b", comb_o, O_MIS); end
    next_cycle();
    ex_mis = 1'b0; #3;
    tests_run++; if (comb_o !== O_LU) begin tests_failed++; $display("FAIL lu_over_branch: got %b want %b", comb_o, O_LU); end
    next_cycle(); idle();
  endtask

  task automatic test_md_op();
    ex_md_start = 1'b1; #3;
    tests_run++; if ({md_busy, comb_o} !== {1'b0, O_IDLE}) begin tests_failed++; $display("FAIL md_start_cycle: got %b want %b", {md_busy, comb_o}, {1'b0, O_IDLE}); end
    next_cycle();
    for (int k = 0; k < MD_LAT; k++) begin
      idle();
      if (k == 2) begin
        ex_memread = 1'b1; ex_rd = 5'd4; id_rs = 5'd4; ex_md_start = 1'b1; id_isbr = 1'b1;
      end
      #3;
      tests_run++; if ({md_busy, comb_o} !== {1'b1, O_MDW}) begin tests_failed++; $display("FAIL md_wait[%0d]: got %b want %b", k, {md_busy, comb_o}, {1'b1, O_MDW}); end
      next_cycle();
    end
    idle(); #3;
    tests_run++; if ({md_busy, comb_o} !== {1'b0, O_IDLE}) begin tests_failed++; $display("FAIL md_done: got %b want %b", {md_busy, comb_o}, {1'b0, O_IDLE}); end
    next_cycle();
  endtask

  task automatic test_exception();
    exc_valid = 1'b1; exc_code = 4'hC; exc_pc = 32'h0040_0010; #3;
    tests_run++; if (comb_o !== O_EXC) begin tests_failed++; $display("FAIL exc_take: got %b want %b", comb_o, O_EXC); end
    next_cycle(); idle(); #3;
    tests_run++; if (comb_o !== O_FLUSH) begin tests_failed++; $display("FAIL exc_flush: got %b want %b", comb_o, O_FLUSH); end
    tests_run++; if ({epc, cause} !== {32'h0040_0010, 4'hC}) begin tests_failed++; $display("FAIL exc_capture: got %h/%h want 00400010/c", epc, cause); end
    next_cycle(); #3;
    tests_run++; if ({in_exc, comb_o} !== {1'b0, O_VEC}) begin tests_failed++; $display("FAIL exc_vector_plus2: got %b want %b", {in_exc, comb_o}, {1'b0, O_VEC}); end
    next_cycle(); #3;
    tests_run++; if ({in_exc, comb_o} !== {1'b1, O_IDLE}) begin tests_failed++; $display("FAIL exc_in_handler: got %b want %b", {in_exc, comb_o}, {1'b1, O_IDLE}); end
    next_cycle();
  endtask

  task automatic test_double_fault_eret();
    exc_valid = 1'b1; exc_code = 4'h3; exc_pc = 32'h0000_1234; #3;
    tests_run++; if (comb_o !== O_IDLE) begin tests_failed++; $display("FAIL df_ignored: got %b want %b", comb_o, O_IDLE); end
    next_cycle(); idle(); #3;
    tests_run++; if ({epc, cause} !== {32'h0040_0010, 4'hC}) begin tests_failed++; $display("FAIL df_epc_kept: got %h/%h want 00400010/c", epc, cause); end
    tests_run++; if ({in_exc, double_fault} !== 2'b11) begin tests_failed++; $display("FAIL df_flag: got %b want 11", {in_exc, double_fault}); end
    next_cycle();
    eret = 1'b1; #3;
    tests_run++; if (comb_o !== O_ERET) begin tests_failed++; $display("FAIL eret: got %b want %b", comb_o, O_ERET); end
    next_cycle(); idle(); #3;
    tests_run++; if ({in_exc, double_fault} !== 2'b01) begin tests_failed++; $display("FAIL eret_clear: got %b want 01", {in_exc, double_fault}); end
    next_cycle();
    eret = 1'b1; id_isbr = 1'b1; #3;
    tests_run++; if (comb_o !== O_BR) begin tests_failed++; $display("FAIL eret_noop: got %b want %b", comb_o, O_BR); end
    next_cycle(); idle();
  endtask

  task automatic test_simultaneous();
    apply_reset();
    exc_valid = 1'b1; exc_code = 4'h9; exc_pc = 32'h000B_EEF0; ex_mis = 1'b1;
    ex_memread = 1'b1; ex_rd = 5'd2; id_rs = 5'd2; id_isbr = 1'b1; #3;
    tests_run++; if (comb_o !== O_EXC || pc_sel === 2'b01) begin tests_failed++; $display("FAIL simul_exc_wins: got %b want %b", comb_o, O_EXC); end
    next_cycle(); idle(); #3;
    tests_run++; if ({cause, comb_o} !== {4'h9, O_FLUSH}) begin tests_failed++; $display("FAIL simul_flush: got %b want %b", {cause, comb_o}, {4'h9, O_FLUSH}); end
    next_cycle(); #3;
    tests_run++; if (comb_o !== O_VEC) begin tests_failed++; $display("FAIL simul_vec: got %b want %b", comb_o, O_VEC); end
    next_cycle();
    eret = 1'b1; #3;
    tests_run++; if ({in_exc, comb_o} !== {1'b1, O_ERET}) begin tests_failed++; $display("FAIL simul_eret: got %b want %b", {in_exc, comb_o}, {1'b1, O_ERET}); end
    next_cycle(); idle(); #3;
    tests_run++; if ({in_exc, double_fault} !== 2'b00) begin tests_failed++; $display("FAIL simul_return: got %b want 00", {in_exc, double_fault}); end
    next_cycle();
  endtask

  task automatic test_md_abort();
    ex_md_start = 1'b1;
    next_cycle(); idle();
    // Wait-state counts run MD_LAT-1 downward; the fifth wait cycle holds count 3
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin exc_valid = 1'b1; exc_code = 4'h5; exc_pc = 32'h0000_0080; end
      #3;
      tests_run++; if ({md_busy, comb_o} !== {1'b1, O_MDW}) begin tests_failed++; $display("FAIL abort_wait[%0d]: got %b want %b", k, {md_busy, comb_o}, {1'b1, O_MDW}); end
      next_cycle();
    end
    idle(); #3;
    tests_run++; if ({md_busy, comb_o} !== {1'b0, O_FLUSH}) begin tests_failed++; $display("FAIL abort_busy_drop: got %b want %b", {md_busy, comb_o}, {1'b0, O_FLUSH}); end
    tests_run++; if ({epc, cause} !== {32'h0000_0080, 4'h5}) begin tests_failed++; $display("FAIL abort_capture: got %h/%h want 00000080/5", epc, cause); end
    next_cycle(); #3;
    tests_run++; if (comb_o !== O_VEC) begin tests_failed++; $display("FAIL abort_vec: got %b want %b", comb_o, O_VEC); end
    next_cycle();
    eret = 1'b1; #3;
    tests_run++; if ({md_busy, in_exc, comb_o} !== {2'b01, O_ERET}) begin tests_failed++; $display("FAIL abort_handler: got %b want %b", {md_busy, in_exc, comb_o}, {2'b01, O_ERET}); end
    next_cycle(); idle();
  endtask

  task automatic test_reset_mid_exc();
    exc_valid = 1'b1; exc_code = 4'hA; exc_pc = 32'h000D_EAD0;
    next_cycle(); idle();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (comb_o !== O_IDLE) begin tests_failed++; $display("FAIL rst_mid_comb: got %b want %b", comb_o, O_IDLE); end
    tests_run++; if ({epc, cause, md_busy, in_exc, double_fault} !== '0) begin tests_failed++; $display("FAIL rst_mid_regs: got %h/%h/%b want 0", epc, cause, {md_busy, in_exc, double_fault}); end
    next_cycle();
    rst_n = 1'b1; #3;
    tests_run++; if (comb_o !== O_IDLE) begin tests_failed++; $display("FAIL rst_mid_no_vec: got %b want %b", comb_o, O_IDLE); end
    next_cycle(); #3;
    tests_run++; if ({in_exc, comb_o} !== {1'b0, O_IDLE}) begin tests_failed++; $display("FAIL rst_mid_after: got %b want %b", {in_exc, comb_o}, {1'b0, O_IDLE}); end
    next_cycle();
  endtask

  task automatic test_random();
    logic [6:0] exp;
    logic       lu;
    for (int r = 0; r < 2; r++) begin
      apply_reset();
      m_md_left = 0; m_exc_steps = 0; m_in_exc = 1'b0; m_df = 1'b0; m_epc = '0; m_cause = '0;
      for (int i = 0; i < 250; i++) begin
        ex_memread  = ($urandom_range(0, 1) == 1);
        ex_rd       = REG_AW'($urandom_range(0, 3));
        id_rs       = REG_AW'($urandom_range(0, 3));
        id_rt       = REG_AW'($urandom_range(0, 3));
        id_uses_rt  = ($urandom_range(0, 1) == 1);
        id_isbr     = ($urandom_range(0, 5) == 0);
        id_isj      = ($urandom_range(0, 7) == 0);
        ex_mis      = ($urandom_range(0, 7) == 0);
        ex_md_start = ($urandom_range(0, 9) == 0);
        exc_valid   = ($urandom_range(0, 11) == 0);
        exc_code    = EXC_W'($urandom);
        exc_pc      = $urandom;
        eret        = ($urandom_range(0, 5) == 0);
        #3;
        lu = ex_memread && (ex_rd != 0) && ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
        if (m_exc_steps == 2)                exp = O_FLUSH;
        else if (m_exc_steps == 1)           exp = O_VEC;
        else if (m_md_left > 0)              exp = O_MDW;
        else if (exc_valid && !m_in_exc)     exp = O_EXC;
        else if (eret && m_in_exc)           exp = O_ERET;
        else if (ex_mis)                     exp = O_MIS;
        else if (ex_md_start)                exp = O_IDLE;
        else if (lu)                         exp = O_LU;
        else if (id_isbr || id_isj)          exp = O_BR;
        else                                 exp = O_IDLE;
        tests_run++; if (comb_o !== exp) begin tests_failed++; $display("FAIL rand_comb[%0d.%0d]: got %b want %b", r, i, comb_o, exp); end
        tests_run++; if ({md_busy, in_exc, double_fault} !== {(m_md_left > 0), m_in_exc, m_df}) begin tests_failed++; $display("FAIL rand_flags[%0d.%0d]: got %b want %b", r, i, {md_busy, in_exc, double_fault}, {(m_md_left > 0), m_in_exc, m_df}); end
        tests_run++; if ({epc, cause} !== {m_epc, m_cause}) begin tests_failed++; $display("FAIL rand_epc[%0d.%0d]: got %h/%h want %h/%h", r, i, epc, cause, m_epc, m_cause); end
        next_cycle();
        if (exc_valid && m_in_exc) m_df = 1'b1;
        if (m_exc_steps == 2) begin
          m_exc_steps = 1;
        end else if (m_exc_steps == 1) begin
          m_exc_steps = 0;
          m_in_exc    = 1'b1;
        end else if (exc_valid && !m_in_exc) begin
          m_epc = exc_pc; m_cause = exc_code; m_exc_steps = 2; m_md_left = 0;
        end else if (m_md_left > 0) begin
          m_md_left--;
        end else if (eret && m_in_exc) begin
          m_in_exc = 1'b0;
        end else if (!ex_mis && ex_md_start) begin
          m_md_left = MD_LAT;
        end
      end
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    #2;
    test_reset();
    test_load_use();
    test_branch();
    test_md_op();
    test_exception();
    test_double_fault_eret();
    test_simultaneous();
    test_md_abort();
    test_reset_mid_exc();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
